// File: rtl/tdes_round_controller.sv
// Round/pass sequencer for a Triple-DES datapath: walks three 16-round DES
// passes (E-D-E or D-E-D), steering key selection and cipher direction.
module tdes_round_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_mode,
  input  logic       i_abort,
  input  logic       i_key_ready,
  output logic       o_load_data,
  output logic       o_key_load,
  output logic [1:0] o_key_sel,
  output logic       o_ed_sel,
  output logic       o_round_en,
  output logic [3:0] o_round_num,
  output logic [1:0] o_pass_num,
  output logic       o_swap_en,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_KEYLD = 3'd2,
    S_ROUND = 3'd3,
    S_SWAP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_round;
  logic [3:0] w_round_nxt;
  logic [1:0] r_pass;
  logic [1:0] w_pass_nxt;
  logic       r_mode;
  logic       w_mode_nxt;
  logic       w_active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_round <= 4'd0;
      r_pass  <= 2'd0;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_round <= w_round_nxt;
      r_pass  <= w_pass_nxt;
      r_mode  <= w_mode_nxt;
    end
  end

  // Every path back to IDLE clears the counters so an idle controller shows zeros.
  always_comb begin
    w_next      = r_state;
    w_round_nxt = r_round;
    w_pass_nxt  = r_pass;
    w_mode_nxt  = r_mode;
    if (i_abort && (r_state != S_IDLE)) begin
      w_next      = S_IDLE;
      w_round_nxt = 4'd0;
      w_pass_nxt  = 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            w_next      = S_LOAD;
            w_mode_nxt  = i_mode;
            w_round_nxt = 4'd0;
            w_pass_nxt  = 2'd0;
          end
        end
        S_LOAD, S_KEYLD: begin
          if (i_key_ready) begin
            w_next = S_ROUND;
          end
        end
        S_ROUND: begin
          if (r_round == 4'd15) begin
            w_next      = S_SWAP;
            w_round_nxt = 4'd0;
          end else begin
            w_round_nxt = r_round + 4'd1;
          end
        end
        S_SWAP: begin
          if (r_pass < 2'd2) begin
            w_pass_nxt = r_pass + 2'd1;
            w_next     = S_KEYLD;
          end else begin
            w_next = S_DONE;
          end
        end
        S_DONE: begin
          w_next      = S_IDLE;
          w_round_nxt = 4'd0;
          w_pass_nxt  = 2'd0;
        end
        default: begin
          w_next      = S_IDLE;
          w_round_nxt = 4'd0;
          w_pass_nxt  = 2'd0;
        end
      endcase
    end
  end

  assign w_active = (r_state != S_IDLE);

  assign o_load_data = (r_state == S_LOAD);
  assign o_key_load  = (r_state == S_LOAD) || (r_state == S_KEYLD);
  assign o_round_en  = (r_state == S_ROUND);
  assign o_swap_en   = (r_state == S_SWAP);
  assign o_done      = (r_state == S_DONE);
  assign o_busy      = (r_state == S_LOAD) || (r_state == S_KEYLD) ||
                       (r_state == S_ROUND) || (r_state == S_SWAP);
  assign o_round_num = r_round;
  assign o_pass_num  = r_pass;

  // Encrypt walks K1,K2,K3 as E,D,E; decrypt walks K3,K2,K1 as D,E,D.
  assign o_key_sel = w_active ? (r_mode ? (2'd2 - r_pass) : r_pass) : 2'd0;
  assign o_ed_sel  = w_active & (r_mode ^ (r_pass == 2'd1));

endmodule

// File: tb/tb_tdes_round_controller.sv
// Directed bench for tdes_round_controller: a progress-count model checked every
// cycle, plus literal latency/schedule expectations for each scenario.
module tb_tdes_round_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic       abort = 1'b0;
  logic       key_ready = 1'b1;
  logic       load_data, key_load, ed_sel, round_en, swap_en, busy, done;
  logic [1:0] key_sel, pass_num;
  logic [3:0] round_num;

  tdes_round_controller dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (start),
    .i_mode      (mode),
    .i_abort     (abort),
    .i_key_ready (key_ready),
    .o_load_data (load_data),
    .o_key_load  (key_load),
    .o_key_sel   (key_sel),
    .o_ed_sel    (ed_sel),
    .o_round_en  (round_en),
    .o_round_num (round_num),
    .o_pass_num  (pass_num),
    .o_swap_en   (swap_en),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait expired", name);
  endtask

  // Model: an operation is a linear progress count t = 0..54.
  // t=0 load; t=1..53 split into 18-cycle pass slots (16 rounds, swap, keyload);
  // t=54 done. Waiting slots advance only when key_ready is high.
  bit m_on = 1'b0;
  int m_t = 0;
  bit m_mode = 1'b0;
  int cyc = 0;

  function automatic bit m_wait(input int t);
    return (t == 0) || ((t >= 1) && (t <= 53) && (((t - 1) % 18) == 17));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_on <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (!m_on) begin
        if (start) begin
          m_on   <= 1'b1;
          m_t    <= 0;
          m_mode <= mode;
        end
      end else if (abort) begin
        m_on <= 1'b0;
      end else if (m_t == 54) begin
        m_on <= 1'b0;
      end else if (!(m_wait(m_t) && !key_ready)) begin
        m_t <= m_t + 1;
      end
    end
  end

  // Bit layout: load,keyload,key_sel[2],ed,round_en,round[4],pass[2],swap,busy,done
  localparam logic [14:0] IDLE_MASK = 15'h6207;

  function automatic logic [14:0] exp_vec();
    logic ld, kl, ed, re, sw, bz, dn;
    int p, r, u, k, ks;
    ld = 0; kl = 0; re = 0; sw = 0; bz = 0; dn = 0;
    p = 0; r = 0;
    if (!m_on) return 15'd0;
    if (m_t == 0) begin
      ld = 1; kl = 1; bz = 1;
    end else if (m_t == 54) begin
      dn = 1; p = 2;
    end else begin
      u = m_t - 1; p = u / 18; k = u % 18; bz = 1;
      if (k < 16) begin re = 1; r = k; end
      else if (k == 16) sw = 1;
      else begin kl = 1; p = p + 1; end
    end
    ks = m_mode ? (2 - p) : p;
    ed = m_mode ^ (p == 1);
    return {ld, kl, 2'(ks), ed, re, 4'(r), 2'(p), sw, bz, dn};
  endfunction

  function automatic logic [14:0] act_vec();
    return {load_data, key_load, key_sel, ed_sel, round_en, round_num, pass_num,
            swap_en, busy, done};
  endfunction

  // Event statistics, only ever incremented here.
  int done_cnt = 0, rnd_cnt = 0, swp_cnt = 0, ld_cnt = 0, r15_cnt = 0;
  int ks_log[256];
  int ed_log[256];

  always @(negedge clk) begin
    logic [14:0] e, a;
    e = exp_vec();
    a = act_vec();
    if (!m_on) begin
      e = e & IDLE_MASK;
      a = a & IDLE_MASK;
    end
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL outputs at cycle %0d: got %h expected %h", cyc, a, e);
    end
    if (done) done_cnt++;
    if (round_en) rnd_cnt++;
    if (round_en && (round_num == 4'd15)) r15_cnt++;
    if (load_data) ld_cnt++;
    if (swap_en) begin
      if (swp_cnt < 256) begin
        ks_log[swp_cnt] = int'(key_sel);
        ed_log[swp_cnt] = int'(ed_sel);
      end
      swp_cnt++;
    end
  end

  int b_done, b_rnd, b_swp, b_ld, b_r15, st;

  task automatic snap();
    b_done = done_cnt; b_rnd = rnd_cnt; b_swp = swp_cnt; b_ld = ld_cnt; b_r15 = r15_cnt;
  endtask

  task automatic wait_done(input string name);
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done) break;
    end
    if (n == 200) timeout_fail(name);
  endtask

  task automatic check_sched(input string name, input int k0, input int k1, input int k2,
                             input int e0, input int e1, input int e2);
    int ek[3];
    int ee[3];
    ek[0] = k0; ek[1] = k1; ek[2] = k2;
    ee[0] = e0; ee[1] = e1; ee[2] = e2;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_key_sel%0d", name, i), ks_log[b_swp + i], ek[i]);
      chk($sformatf("%s_ed_sel%0d", name, i), ed_log[b_swp + i], ee[i]);
    end
  endtask

  initial begin
    int n;
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", int'(act_vec()), 0);
    rst = 1'b0;
    @(negedge clk);

    // Encrypt, key always ready
    snap(); mode = 1'b0; start = 1'b1;
    @(negedge clk); st = cyc; start = 1'b0;
    wait_done("enc_done_wait");
    chk("enc_latency", cyc - st, 54);
    chk("enc_round_en_cycles", rnd_cnt - b_rnd, 48);
    chk("enc_swaps", swp_cnt - b_swp, 3);
    chk("enc_load_cycles", ld_cnt - b_ld, 1);
    check_sched("enc", 0, 1, 2, 0, 1, 0);
    @(negedge clk);
    chk("enc_idle_busy", int'(busy), 0);
    chk("enc_done_count", done_cnt - b_done, 1);

    // Decrypt, mode flipped right after acceptance
    snap(); mode = 1'b1; start = 1'b1;
    @(negedge clk); st = cyc; start = 1'b0; mode = 1'b0;
    wait_done("dec_done_wait");
    chk("dec_latency", cyc - st, 54);
    chk("dec_round15_count", r15_cnt - b_r15, 3);
    chk("dec_swaps", swp_cnt - b_swp, 3);
    chk("dec_load_cycles", ld_cnt - b_ld, 1);
    check_sched("dec", 2, 1, 0, 1, 0, 1);
    @(negedge clk);

    // key_ready stalls: 3 cycles in LOAD, 2 in pass-1 KEYLD
    snap(); mode = 1'b0; key_ready = 1'b0; start = 1'b1;
    @(negedge clk); st = cyc; start = 1'b0;
    repeat (3) @(negedge clk);
    key_ready = 1'b1;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (key_load && !load_data && (pass_num == 2'd1)) break;
    end
    if (n == 100) timeout_fail("stall_keyld_wait");
    key_ready = 1'b0;
    repeat (2) @(negedge clk);
    key_ready = 1'b1;
    wait_done("stall_done_wait");
    chk("stall_latency", cyc - st, 59);
    chk("stall_round_en_cycles", rnd_cnt - b_rnd, 48);
    @(negedge clk);

    // Abort at pass 1 round 7, then a clean restart
    snap(); mode = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (round_en && (pass_num == 2'd1) && (round_num == 4'd7)) break;
    end
    if (n == 100) timeout_fail("abort_point_wait");
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_round_en", int'(round_en), 0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_cnt - b_done, 0);
    snap(); start = 1'b1;
    @(negedge clk); st = cyc; start = 1'b0;
    wait_done("restart_done_wait");
    chk("restart_latency", cyc - st, 54);
    @(negedge clk);

    // start held high: ignored while busy and in DONE, accepted again from IDLE
    snap(); mode = 1'b1; start = 1'b1;
    @(negedge clk); st = cyc;
    wait_done("held_done_wait");
    chk("held_latency", cyc - st, 54);
    chk("held_single_load", ld_cnt - b_ld, 1);
    @(negedge clk);
    chk("held_idle_busy", int'(busy), 0);
    @(negedge clk);
    chk("held_restart_load", int'(load_data), 1);

    // Asynchronous reset in the middle of pass 2
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (round_en && (pass_num == 2'd2) && (round_num == 4'd5)) break;
    end
    if (n == 100) timeout_fail("rst_point_wait");
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", int'(act_vec()), 0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_reset_idle", int'(busy), 0);
    chk("post_reset_done_count", done_cnt - b_done, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdes_round_controller.md
TDES_ROUND_CONTROLLER -- requirements
Module: tdes_round_controller

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 start  in  1  request to begin one Triple-DES operation; sampled only in IDLE.
REQ-004 mode  in  1  0 = encrypt (E-D-E), 1 = decrypt (D-E-D); latched when start is accepted.
REQ-005 abort  in  1  synchronous cancel of an in-progress operation.
REQ-006 key_ready  in  1  key schedule has loaded the selected key; sampled in LOAD and KEYLD.
REQ-007 load_data  out  1  datapath loads its input block and applies the initial permutation.
REQ-008 key_load  out  1  key schedule loads the key chosen by key_sel.
REQ-009 key_sel  out  2  active key: 0 = K1, 1 = K2, 2 = K3; value 3 never driven.
REQ-010 ed_sel  out  1  DES direction for the current pass: 0 = encrypt, 1 = decrypt.
REQ-011 round_en  out  1  datapath executes one Feistel round this cycle.
REQ-012 round_num  out  4  index of the current round, 0 to 15.
REQ-013 pass_num  out  2  index of the current DES pass, 0 to 2.
REQ-014 swap_en  out  1  datapath applies the final swap and inverse permutation for the pass.
REQ-015 busy  out  1  operation in progress.
REQ-016 done  out  1  one-cycle pulse: result valid.

Function
REQ-017 The controller SHALL be a Moore FSM with states IDLE, LOAD, KEYLD, ROUND, SWAP and DONE; all outputs SHALL be registered or decoded from registered state only.
REQ-018 IDLE: if start=1, the controller SHALL latch mode, clear pass_num and round_num, and go to LOAD; start SHALL be ignored in every other state.
REQ-019 LOAD: load_data=1 and key_load=1; the controller SHALL stay in LOAD while key_ready=0 and go to ROUND when key_ready=1.
REQ-020 ROUND: round_en=1; round_num SHALL increment each cycle; at round_num=15 the controller SHALL go to SWAP and round_num SHALL wrap to 0.
REQ-021 SWAP: swap_en=1; if pass_num<2 the controller SHALL increment pass_num and go to KEYLD, otherwise it SHALL go to DONE.
REQ-022 KEYLD: key_load=1; the controller SHALL stay while key_ready=0 and go to ROUND when key_ready=1; load_data SHALL NOT assert.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE.
REQ-024 Encrypt pass schedule (pass 0,1,2): key_sel = 0,1,2; ed_sel = 0,1,0.
REQ-025 Decrypt pass schedule (pass 0,1,2): key_sel = 2,1,0; ed_sel = 1,0,1.
REQ-026 key_sel and ed_sel SHALL be valid in every non-IDLE state for the current pass_num, and SHALL hold their values throughout each pass.
REQ-027 busy SHALL be 1 in LOAD, KEYLD, ROUND and SWAP, and 0 in IDLE and DONE.
REQ-028 With key_ready held at 1, a start accepted at edge N SHALL give done=1 in the cycle following edge N+54: 3 x 16 round cycles, 3 swap cycles, 1 LOAD cycle, 2 KEYLD cycles.
REQ-029 Each cycle of key_ready=0 in LOAD or KEYLD SHALL add exactly one cycle of latency.
REQ-030 abort=1 in any state other than IDLE SHALL force IDLE at the next edge, without asserting done; abort SHALL take priority over all other transitions.
REQ-031 start=1 arriving in the DONE cycle SHALL be ignored; a new start is accepted from IDLE only.
REQ-032 Changing mode while busy SHALL NOT affect the operation in progress.

Reset
REQ-033 While rst=1, the FSM SHALL be IDLE and every output SHALL be 0, including key_sel, round_num and pass_num, independent of clk.
REQ-034 Asserting rst mid-operation SHALL abandon the operation immediately; after release, the controller SHALL wait in IDLE for a new start.

Verification
REQ-035 Encrypt, key_ready=1, start pulse at edge N -> 48 round_en cycles; key_sel/ed_sel = 0/0, 1/1, 2/0 per pass; done in the cycle after edge N+54.
REQ-036 Decrypt, key_ready=1 -> key_sel/ed_sel = 2/1, 1/0, 0/1; round_num runs 0 to 15 three times; exactly 3 swap_en and 1 load_data pulses.
REQ-037 key_ready held low 3 cycles in LOAD and 2 cycles in the pass-1 KEYLD -> done arrives 5 cycles later than in REQ-035; round_en stays 0 while waiting.
REQ-038 abort at pass 1, round 7 -> IDLE next edge, busy=0, no done; a subsequent start completes normally.
REQ-039 rst pulsed mid pass 2 -> all outputs 0 asynchronously; start held high throughout a busy operation -> no second operation begins before IDLE.
